// File: rtl/acc_predecoder_multi.sv
`default_nettype none
// ============================================================================
// acc_predecoder_multi : table-driven offload predecoder with per-accelerator
//                        in-flight credit tracking and response register
// Revision: 1.0
// ============================================================================
module acc_predecoder_multi #(
  parameter int NumAcc         = 4,
  parameter int NumEntries     = 8,
  parameter int MaxOutstanding = 4,
  parameter int WbW            = 2,
  parameter int NumRs          = 3,
  localparam int AccIdW        = (NumAcc > 1) ? $clog2(NumAcc) : 1,
  localparam int IdxW          = (NumEntries > 1) ? $clog2(NumEntries) : 1,
  localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              q_valid_i,
  output logic              q_ready_o,
  input  logic [31:0]       q_instr_data_i,
  output logic              p_valid_o,
  input  logic              p_ready_i,
  output logic              p_accept_o,
  output logic [WbW-1:0]    p_writeback_o,
  output logic [NumRs-1:0]  p_use_rs_o,
  output logic [AccIdW-1:0] p_acc_id_o,
  input  logic              cmpl_valid_i,
  input  logic [AccIdW-1:0] cmpl_acc_i,
  input  logic              cfg_we_i,
  input  logic [IdxW-1:0]   cfg_idx_i,
  input  logic [31:0]       cfg_data_i,
  input  logic [31:0]       cfg_mask_i,
  input  logic              cfg_accept_i,
  input  logic [WbW-1:0]    cfg_writeback_i,
  input  logic [NumRs-1:0]  cfg_use_rs_i,
  input  logic [AccIdW-1:0] cfg_acc_i,
  input  logic              cfg_clear_i,
  output logic [NumAcc-1:0] busy_o,
  output logic              cnt_err_o
);

  // Match table
  logic [NumEntries-1:0] valid_q, valid_d;
  logic [31:0]           data_q   [NumEntries];
  logic [31:0]           data_d   [NumEntries];
  logic [31:0]           mask_q   [NumEntries];
  logic [31:0]           mask_d   [NumEntries];
  logic                  accept_q [NumEntries];
  logic                  accept_d [NumEntries];
  logic [WbW-1:0]        wb_q     [NumEntries];
  logic [WbW-1:0]        wb_d     [NumEntries];
  logic [NumRs-1:0]      rs_q     [NumEntries];
  logic [NumRs-1:0]      rs_d     [NumEntries];
  logic [AccIdW-1:0]     acc_q    [NumEntries];
  logic [AccIdW-1:0]     acc_d    [NumEntries];

  // Credit counters
  logic [CntW-1:0]       cnt_q [NumAcc];
  logic [CntW-1:0]       cnt_d [NumAcc];
  logic                  cnt_err_q, cnt_err_d;

  // Response register
  logic                  p_valid_q, p_valid_d;
  logic                  p_accept_q, p_accept_d;
  logic [WbW-1:0]        p_wb_q, p_wb_d;
  logic [NumRs-1:0]      p_rs_q, p_rs_d;
  logic [AccIdW-1:0]     p_id_q, p_id_d;

  logic                  hit;
  logic [IdxW-1:0]       win_idx;
  logic                  win_accept;
  logic [AccIdW-1:0]     win_acc;
  logic [CntW-1:0]       win_cnt;
  logic                  stall;
  logic                  fire;

  // Descending scan so the lowest-index hit is the last assignment standing.
  always_comb begin
    hit     = 1'b0;
    win_idx = '0;
    for (int e = NumEntries - 1; e >= 0; e--) begin
      if (valid_q[e] && ((q_instr_data_i & mask_q[e]) == (data_q[e] & mask_q[e]))) begin
        hit     = 1'b1;
        win_idx = IdxW'(e);
      end
    end
  end

  assign win_accept = hit && accept_q[win_idx];
  assign win_acc    = hit ? acc_q[win_idx] : '0;

  // Out-of-range accelerator ids see a zero count and therefore never stall.
  always_comb begin
    win_cnt = '0;
    for (int a = 0; a < NumAcc; a++) begin
      if (win_acc == AccIdW'(a)) begin
        win_cnt = cnt_q[a];
      end
    end
  end

  assign stall     = win_accept && (win_cnt == CntW'(MaxOutstanding));
  assign q_ready_o = (!p_valid_q || p_ready_i) && !stall;
  assign fire      = q_valid_i && q_ready_o;

  always_comb begin
    p_valid_d  = p_valid_q;
    p_accept_d = p_accept_q;
    p_wb_d     = p_wb_q;
    p_rs_d     = p_rs_q;
    p_id_d     = p_id_q;
    if (fire) begin
      p_valid_d  = 1'b1;
      p_accept_d = win_accept;
      p_wb_d     = win_accept ? wb_q[win_idx] : '0;
      p_rs_d     = win_accept ? rs_q[win_idx] : '0;
      p_id_d     = win_acc;
    end else if (p_ready_i) begin
      p_valid_d  = 1'b0;
    end
  end

  always_comb begin
    cnt_err_d = cnt_err_q;
    for (int a = 0; a < NumAcc; a++) begin
      logic inc;
      logic dec;
      inc      = fire && win_accept && (win_acc == AccIdW'(a));
      dec      = cmpl_valid_i && (cmpl_acc_i == AccIdW'(a));
      cnt_d[a] = cnt_q[a];
      if (inc && !dec) begin
        cnt_d[a] = cnt_q[a] + CntW'(1);
      end else if (dec && !inc) begin
        if (cnt_q[a] == '0) begin
          cnt_err_d = 1'b1;
        end else begin
          cnt_d[a] = cnt_q[a] - CntW'(1);
        end
      end
    end
  end

  // Table writes land at the edge, so a same-cycle lookup sees the old entry.
  always_comb begin
    valid_d = valid_q;
    for (int e = 0; e < NumEntries; e++) begin
      data_d[e]   = data_q[e];
      mask_d[e]   = mask_q[e];
      accept_d[e] = accept_q[e];
      wb_d[e]     = wb_q[e];
      rs_d[e]     = rs_q[e];
      acc_d[e]    = acc_q[e];
    end
    if (cfg_clear_i) begin
      valid_d = '0;
    end else if (cfg_we_i && (int'(cfg_idx_i) < NumEntries)) begin
      valid_d[cfg_idx_i]  = 1'b1;
      data_d[cfg_idx_i]   = cfg_data_i;
      mask_d[cfg_idx_i]   = cfg_mask_i;
      accept_d[cfg_idx_i] = cfg_accept_i;
      wb_d[cfg_idx_i]     = cfg_writeback_i;
      rs_d[cfg_idx_i]     = cfg_use_rs_i;
      acc_d[cfg_idx_i]    = cfg_acc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      cnt_err_q  <= 1'b0;
      p_valid_q  <= 1'b0;
      p_accept_q <= 1'b0;
      p_wb_q     <= '0;
      p_rs_q     <= '0;
      p_id_q     <= '0;
      for (int e = 0; e < NumEntries; e++) begin
        data_q[e]   <= '0;
        mask_q[e]   <= '0;
        accept_q[e] <= 1'b0;
        wb_q[e]     <= '0;
        rs_q[e]     <= '0;
        acc_q[e]    <= '0;
      end
      for (int a = 0; a < NumAcc; a++) begin
        cnt_q[a] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      cnt_err_q  <= cnt_err_d;
      p_valid_q  <= p_valid_d;
      p_accept_q <= p_accept_d;
      p_wb_q     <= p_wb_d;
      p_rs_q     <= p_rs_d;
      p_id_q     <= p_id_d;
      for (int e = 0; e < NumEntries; e++) begin
        data_q[e]   <= data_d[e];
        mask_q[e]   <= mask_d[e];
        accept_q[e] <= accept_d[e];
        wb_q[e]     <= wb_d[e];
        rs_q[e]     <= rs_d[e];
        acc_q[e]    <= acc_d[e];
      end
      for (int a = 0; a < NumAcc; a++) begin
        cnt_q[a] <= cnt_d[a];
      end
    end
  end

  generate
    for (genvar a = 0; a < NumAcc; a++) begin : g_busy
      assign busy_o[a] = (cnt_q[a] != '0);
    end
  endgenerate

  assign p_valid_o     = p_valid_q;
  assign p_accept_o    = p_accept_q;
  assign p_writeback_o = p_wb_q;
  assign p_use_rs_o    = p_rs_q;
  assign p_acc_id_o    = p_id_q;
  assign cnt_err_o     = cnt_err_q;

endmodule

`default_nettype wire

// File: tb/tb_acc_predecoder_multi.sv
`default_nettype none
// ============================================================================
// tb_acc_predecoder_multi : directed + random bench against a table/credit model
// Revision: 1.0
// ============================================================================
module tb_acc_predecoder_multi;

  localparam int NACC = 4;
  localparam int NENT = 8;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        q_valid, q_ready;
  logic [31:0] q_instr;
  logic        p_valid, p_ready, p_accept;
  logic [1:0]  p_wb;
  logic [2:0]  p_rs;
  logic [1:0]  p_id;
  logic        cmpl_valid;
  logic [1:0]  cmpl_acc;
  logic        cfg_we, cfg_accept, cfg_clear;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_data, cfg_mask;
  logic [1:0]  cfg_wb, cfg_acc;
  logic [2:0]  cfg_rs;
  logic [3:0]  busy;
  logic        cnt_err;

  always #5 clk = ~clk;

  acc_predecoder_multi dut (
    .clk_i(clk), .rst_ni(rst_n),
    .q_valid_i(q_valid), .q_ready_o(q_ready), .q_instr_data_i(q_instr),
    .p_valid_o(p_valid), .p_ready_i(p_ready), .p_accept_o(p_accept),
    .p_writeback_o(p_wb), .p_use_rs_o(p_rs), .p_acc_id_o(p_id),
    .cmpl_valid_i(cmpl_valid), .cmpl_acc_i(cmpl_acc),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_data_i(cfg_data), .cfg_mask_i(cfg_mask),
    .cfg_accept_i(cfg_accept), .cfg_writeback_i(cfg_wb), .cfg_use_rs_i(cfg_rs),
    .cfg_acc_i(cfg_acc), .cfg_clear_i(cfg_clear),
    .busy_o(busy), .cnt_err_o(cnt_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: table contents, outstanding counts, held response
  bit        m_valid [NENT];
  bit [31:0] m_data  [NENT];
  bit [31:0] m_mask  [NENT];
  bit        m_acc_b [NENT];
  bit [1:0]  m_wb    [NENT];
  bit [2:0]  m_rs    [NENT];
  int        m_acc   [NENT];
  int        m_cnt   [NACC];
  bit        m_err, m_pv, m_pa;
  bit [1:0]  m_pwb;
  bit [2:0]  m_prs;
  int        m_pid;

  // Snapshot of DUT outputs taken at the last step's sample point
  logic       s_pvalid, s_accept, s_ready, s_err;
  logic [1:0] s_wb, s_id;
  logic [2:0] s_rs;
  logic [3:0] s_busy;

  task automatic m_reset();
    for (int e = 0; e < NENT; e++) m_valid[e] = 0;
    for (int a = 0; a < NACC; a++) m_cnt[a] = 0;
    m_err = 0; m_pv = 0; m_pa = 0; m_pwb = 0; m_prs = 0; m_pid = 0;
  endtask

  function automatic int lookup(input logic [31:0] ins);
    for (int e = 0; e < NENT; e++)
      if (m_valid[e] && (((ins ^ m_data[e]) & m_mask[e]) == 0)) return e;
    return -1;
  endfunction

  function automatic bit model_ready();
    int  e;
    bit  stall;
    e = lookup(q_instr);
    stall = (e >= 0) && m_acc_b[e] && (m_cnt[m_acc[e]] == MAXO);
    return (!m_pv || p_ready) && !stall;
  endfunction

  // One clock: sample/check at negedge, advance the model at posedge.
  task automatic step();
    int         e;
    bit         fire, inc, dec;
    logic [3:0] exp_busy;
    @(negedge clk);
    s_pvalid = p_valid; s_accept = p_accept; s_wb = p_wb; s_rs = p_rs; s_id = p_id;
    s_ready = q_ready; s_busy = busy; s_err = cnt_err;
    for (int a = 0; a < NACC; a++) exp_busy[a] = (m_cnt[a] != 0);
    check("p_valid", p_valid, m_pv);
    if (m_pv) begin
      check("p_accept", p_accept, m_pa);
      check("p_writeback", p_wb, m_pwb);
      check("p_use_rs", p_rs, m_prs);
      check("p_acc_id", p_id, m_pid);
    end
    check("busy", busy, exp_busy);
    check("cnt_err", cnt_err, m_err);
    check("q_ready", q_ready, model_ready());
    fire = q_valid && model_ready();
    e = lookup(q_instr);
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else begin
      inc = 0;
      if (fire) begin
        m_pv  = 1;
        m_pa  = (e >= 0) && m_acc_b[e];
        m_pwb = m_pa ? m_wb[e] : 2'b00;
        m_prs = m_pa ? m_rs[e] : 3'b000;
        m_pid = (e >= 0) ? m_acc[e] : 0;
        inc   = m_pa;
      end else if (p_ready) begin
        m_pv = 0;
      end
      for (int a = 0; a < NACC; a++) begin
        bit ia;
        ia  = inc && (m_acc[e] == a);
        dec = cmpl_valid && (int'(cmpl_acc) == a);
        if (ia && !dec) m_cnt[a]++;
        else if (dec && !ia) begin
          if (m_cnt[a] == 0) m_err = 1;
          else m_cnt[a]--;
        end
      end
      if (cfg_clear) begin
        for (int i = 0; i < NENT; i++) m_valid[i] = 0;
      end else if (cfg_we) begin
        m_valid[cfg_idx] = 1; m_data[cfg_idx] = cfg_data; m_mask[cfg_idx] = cfg_mask;
        m_acc_b[cfg_idx] = cfg_accept; m_wb[cfg_idx] = cfg_wb; m_rs[cfg_idx] = cfg_rs;
        m_acc[cfg_idx] = int'(cfg_acc);
      end
    end
    #1;
  endtask

  task automatic idle();
    q_valid = 0; q_instr = 0; p_ready = 1; cmpl_valid = 0; cmpl_acc = 0;
    cfg_we = 0; cfg_idx = 0; cfg_data = 0; cfg_mask = 0; cfg_accept = 0;
    cfg_wb = 0; cfg_rs = 0; cfg_acc = 0; cfg_clear = 0;
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] d, input logic [31:0] m,
                           input bit acc_b, input logic [1:0] wb, input logic [2:0] rs,
                           input int acc);
    cfg_we = 1; cfg_idx = 3'(idx); cfg_data = d; cfg_mask = m; cfg_accept = acc_b;
    cfg_wb = wb; cfg_rs = rs; cfg_acc = 2'(acc);
    step();
    cfg_we = 0;
  endtask

  task automatic offer(input logic [31:0] ins);
    q_valid = 1; q_instr = ins;
    step();
    q_valid = 0;
    step();
  endtask

  task automatic randomize_inputs();
    logic [31:0] lows [5];
    lows[0] = 32'h0B; lows[1] = 32'h2B; lows[2] = 32'h5B; lows[3] = 32'h7B; lows[4] = 32'h73;
    q_valid    = ($urandom_range(3) != 0);
    q_instr    = ($urandom() & 32'hFFFF_FF80) | lows[$urandom_range(4)];
    p_ready    = ($urandom_range(3) != 0);
    cmpl_valid = ($urandom_range(2) == 0);
    cmpl_acc   = 2'($urandom_range(3));
    cfg_we     = ($urandom_range(7) == 0);
    cfg_clear  = ($urandom_range(59) == 0);
    cfg_idx    = 3'($urandom_range(7));
    cfg_data   = ($urandom() & 32'h0000_7000) | lows[$urandom_range(4)];
    case ($urandom_range(3))
      0: cfg_mask = 32'h0000_003F;
      1: cfg_mask = 32'h0000_707F;
      default: cfg_mask = 32'h0000_007F;
    endcase
    cfg_accept = ($urandom_range(3) != 0);
    cfg_wb     = 2'($urandom_range(3));
    cfg_rs     = 3'($urandom_range(7));
    cfg_acc    = 2'($urandom_range(3));
  endtask

  initial begin
    idle();
    m_reset();
    rst_n = 0;
    step(); step();
    check("rst_p_valid", s_pvalid, 0);
    check("rst_q_ready", s_ready, 1);
    check("rst_busy", s_busy, 0);
    check("rst_cnt_err", s_err, 0);
    rst_n = 1;

    // Unconfigured table: response with accept=0
    offer(32'h0000_0073);
    check("tp1_p_valid", s_pvalid, 1);
    check("tp1_accept", s_accept, 0);
    check("tp1_acc_id", s_id, 0);
    check("tp1_busy", s_busy, 0);

    cfg_write(0, 32'h0000_000B, 32'h0000_007F, 1, 2'b01, 3'b011, 2);
    offer(32'h1234_500B);
    check("tp2_accept", s_accept, 1);
    check("tp2_wb", s_wb, 2'b01);
    check("tp2_rs", s_rs, 3'b011);
    check("tp2_acc_id", s_id, 2);
    check("tp2_busy", s_busy, 4'b0100);

    // Overlapping entries: lowest index wins
    cfg_write(1, 32'h0000_002B, 32'h0000_007F, 1, 2'b10, 3'b001, 1);
    cfg_write(3, 32'h0000_002B, 32'h0000_003F, 1, 2'b11, 3'b111, 3);
    offer(32'hABC0_002B);
    check("tp3_priority_id", s_id, 1);
    cfg_clear = 1; step(); cfg_clear = 0;
    offer(32'hABC0_002B);
    check("tp3_cleared_accept", s_accept, 0);

    // Credit exhaustion on acc 2
    cfg_write(0, 32'h0000_000B, 32'h0000_007F, 1, 2'b01, 3'b011, 2);
    q_valid = 1; q_instr = 32'h0000_100B; p_ready = 1;
    for (int i = 0; i < 8 && m_cnt[2] < MAXO; i++) step();
    step();
    check("tp4_stall", s_ready, 0);
    cmpl_valid = 1; cmpl_acc = 2;
    step();
    check("tp4_no_bypass", s_ready, 0);
    cmpl_valid = 0; q_valid = 0;
    step();
    check("tp4_release", s_ready, 1);

    // Response hold under back-pressure
    q_valid = 1; q_instr = 32'h0000_0073;
    step();
    p_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("tp5_hold_valid", s_pvalid, 1);
      check("tp5_hold_ready", s_ready, 0);
    end
    p_ready = 1; q_valid = 0;
    step();

    // Fire and completion on the same accelerator in one cycle
    q_valid = 1; q_instr = 32'h0000_000B; cmpl_valid = 1; cmpl_acc = 2;
    step();
    cmpl_valid = 0;
    step();
    step();
    check("tp5_net_stall", s_ready, 0);
    q_valid = 0;
    for (int i = 0; i < MAXO; i++) begin
      cmpl_valid = 1; cmpl_acc = 2; step();
    end
    cmpl_valid = 0;

    // Completion underflow is sticky
    cmpl_valid = 1; cmpl_acc = 0;
    step();
    cmpl_valid = 0;
    step();
    check("tp6_cnt_err", s_err, 1);
    step(); step();
    check("tp6_cnt_err_sticky", s_err, 1);

    // Asynchronous reset mid-stream
    offer(32'h0000_000B);
    #2;
    rst_n = 0;
    #1;
    check("arst_p_valid", p_valid, 0);
    check("arst_p_accept", p_accept, 0);
    check("arst_p_acc_id", p_id, 0);
    check("arst_q_ready", q_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_cnt_err", cnt_err, 0);
    m_reset();
    step();
    rst_n = 1;

    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/acc_predecoder_multi.md
Name: acc_predecoder_multi

Overview:
- Programmable, multi-accelerator offload predecoder.
- Sits between the core's offload request port and NumAcc accelerators.
- Matches each offered 32-bit instruction against a runtime-written table of (data, mask, response, accelerator id) entries and returns a registered predecoder response: accept, writeback, use_rs and the target id.
- Tracks in-flight offloads per accelerator and back-pressures the core when the target's credit budget is exhausted.

Parameters:
- NumAcc, 4, number of accelerators; AccIdW = max(1, $clog2(NumAcc)).
- NumEntries, 8, match table depth; IdxW = max(1, $clog2(NumEntries)).
- MaxOutstanding, 4, max accepted-but-uncompleted offloads per accelerator (>=1); CntW = $clog2(MaxOutstanding+1).
- WbW, 2, width of writeback field.
- NumRs, 3, width of use_rs field.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- q_valid_i  in  1  offload request valid
- q_ready_o  out  1  offload request ready
- q_instr_data_i  in  32  instruction word
- p_valid_o  out  1  response valid
- p_ready_i  in  1  response ready
- p_accept_o  out  1  instruction accepted
- p_writeback_o  out  WbW  writeback flags
- p_use_rs_o  out  NumRs  source-register usage
- p_acc_id_o  out  AccIdW  target accelerator
- cmpl_valid_i  in  1  one offload completed
- cmpl_acc_i  in  AccIdW  accelerator that completed
- cfg_we_i  in  1  table entry write
- cfg_idx_i  in  IdxW  entry index
- cfg_data_i  in  32  match data
- cfg_mask_i  in  32  match mask
- cfg_accept_i  in  1  entry accept bit
- cfg_writeback_i  in  WbW  entry writeback
- cfg_use_rs_i  in  NumRs  entry use_rs
- cfg_acc_i  in  AccIdW  entry accelerator id
- cfg_clear_i  in  1  invalidate all entries
- busy_o  out  NumAcc  bit a = counter[a] != 0
- cnt_err_o  out  1  sticky: completion while counter 0

Behaviour:
- Reset (async, rst_ni=0): all entry valid bits 0, all counters 0, p_valid_o=0. All p_* data outputs are 0; q_ready_o=1, busy_o=0, cnt_err_o=0.
- Match:
  - Entry e hits iff valid[e] && ((q_instr_data_i & mask[e]) == (data[e] & mask[e])).
  - The lowest-index hit wins.
  - No hit gives response accept=0, writeback=0, use_rs=0, acc_id=0.
  - A winning entry with accept=0 gives accept=0, writeback=0, use_rs=0 and acc_id=entry id, and consumes no credit.
- Credit stall: stall = hit && win.accept && (counter[win.acc] == MaxOutstanding), using registered counter values. A completion arriving in the same cycle does not bypass; the stall releases in the next cycle.
- q_ready_o = (!p_valid_o || p_ready_i) && !stall, combinational from q_instr_data_i.
- Request fire (q_valid_i && q_ready_o):
  - The response register loads next edge, so latency is exactly 1 cycle; p_valid_o=1.
  - If win.accept=1, counter[win.acc] increments.
- Response hold: while p_valid_o && !p_ready_i, the p_* outputs stay stable. p_ready_i without a new fire clears p_valid_o. A back-to-back fire and drain sustains 1 response per cycle.
- Completion: cmpl_valid_i decrements counter[cmpl_acc_i].
  - Increment and decrement on the same acc in the same cycle: net unchanged.
  - Decrement at 0: counter stays 0 and cnt_err_o sets; it is cleared only by reset.
  - cmpl_acc_i >= NumAcc is ignored.
- Config:
  - cfg_we_i writes the entry at the edge and sets valid=1; cfg_idx_i >= NumEntries is ignored.
  - A lookup in the same cycle as a write uses the old contents; the new entry is visible from the next cycle.
  - cfg_clear_i clears all valid bits and takes priority over cfg_we_i in the same cycle.
  - Config does not affect a response already registered or counters already incremented.
- q_valid_i dropping without a fire is legal; the block keeps no request state.

Test Plan:
- Reset, no config; offer 0x0000_0073 -> 1 cycle later p_valid_o=1, p_accept_o=0, p_acc_id_o=0; busy_o=0.
- Entry0: data=0x0000_000B, mask=0x0000_007F, accept=1, wb=01, rs=011, acc=2; offer 0x1234_500B -> p_accept_o=1, p_writeback_o=01, p_use_rs_o=011, p_acc_id_o=2; busy_o=4'b0100.
- Entries 1 and 3 overlap (acc 1 vs acc 3); offer an instruction hitting both -> p_acc_id_o=1. Clear entry priority by cfg_clear_i -> next offer gives accept=0.
- Acc 2: 4 accepted offloads with p_ready_i=1 -> 5th offer sees q_ready_o=0. Raise cmpl_valid_i for acc 2 -> q_ready_o=1 the following cycle, not the same one.
- Hold p_ready_i=0 for 3 cycles with p_valid_o=1 -> outputs stable and q_ready_o=0. Simultaneous fire and completion on the same acc -> counter unchanged.
- cmpl_valid_i for acc 0 with counter 0 -> cnt_err_o=1 and stays 1. Assert rst_ni mid-stream -> all outputs return to reset values asynchronously.
